// File: rtl/fetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_buffer
// Description : Sequential instruction prefetcher. It keeps at most one word
//               request outstanding to instruction memory and buffers up to
//               DEPTH {instruction, pc} pairs for the fetch stage. A redirect
//               flushes the buffer, drops any in-flight response and restarts
//               fetching at the redirect target.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    output logic                       o_imem_req,
    output logic [31:0]                o_imem_addr,
    input  logic                       i_imem_ack,
    input  logic                       i_imem_rvalid,
    input  logic [31:0]                i_imem_rdata,
    input  logic                       i_redirect,
    input  logic [31:0]                i_redirect_pc,
    input  logic                       i_consume,
    output logic                       o_valid,
    output logic [31:0]                o_instr,
    output logic [31:0]                o_pc,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    // FETCH issues a request, WAIT expects its response, DISCARD expects a
    // response that belongs to a flushed request and must be thrown away.
    localparam logic [1:0] c_st_fetch   = 2'd0;
    localparam logic [1:0] c_st_wait    = 2'd1;
    localparam logic [1:0] c_st_discard = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [31:0]         r_fetch_pc;
    logic [31:0]         r_req_pc;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [31:0]         r_instr_mem [DEPTH];
    logic [31:0]         r_pc_mem    [DEPTH];

    logic                w_req;
    logic                w_fire;
    logic                w_wr;
    logic                w_rd;
    logic                w_unused;

    // The low address bits of a redirect target carry no meaning for word fetches.
    assign w_unused = &{1'b0, i_redirect_pc[1:0]};

    // A request is only raised while there is guaranteed room for its response.
    assign w_req  = i_rst && (r_state == c_st_fetch) && (r_count < c_depth);
    assign w_fire = w_req && i_imem_ack;
    assign w_wr   = !i_redirect && (r_state == c_st_wait) && i_imem_rvalid;
    assign w_rd   = !i_redirect && i_consume && (r_count != '0);

    assign o_imem_req  = w_req;
    assign o_imem_addr = i_rst ? r_fetch_pc : RESET_PC;
    assign o_valid     = i_rst && (r_count != '0);
    assign o_count     = i_rst ? r_count : '0;
    assign o_instr     = r_instr_mem[r_rd_ptr];
    assign o_pc        = r_pc_mem[r_rd_ptr];

    // Next-state selection; a redirect decides whether a response is still owed.
    always_comb begin
        w_state_nxt = r_state;
        if (i_redirect) begin
            case (r_state)
                c_st_fetch:   w_state_nxt = w_fire ? c_st_discard : c_st_fetch;
                c_st_wait:    w_state_nxt = i_imem_rvalid ? c_st_fetch : c_st_discard;
                c_st_discard: w_state_nxt = i_imem_rvalid ? c_st_fetch : c_st_discard;
                default:      w_state_nxt = c_st_fetch;
            endcase
        end else begin
            case (r_state)
                c_st_fetch:   if (w_fire)        w_state_nxt = c_st_wait;
                c_st_wait:    if (i_imem_rvalid) w_state_nxt = c_st_fetch;
                c_st_discard: if (i_imem_rvalid) w_state_nxt = c_st_fetch;
                default:      w_state_nxt = c_st_fetch;
            endcase
        end
    end

    // State, fetch address and buffer bookkeeping.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= c_st_fetch;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_redirect) begin
                r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_fire) begin
                    r_req_pc   <= r_fetch_pc;
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                if (w_rd) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                r_count <= r_count + c_cnt_w'(w_wr) - c_cnt_w'(w_rd);
            end
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_wr) begin
            r_instr_mem[r_wr_ptr] <= i_imem_rdata;
            r_pc_mem[r_wr_ptr]    <= r_req_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_buffer
// Description : Directed self-checking bench for fetch_prefetch_buffer with an
//               expected-entry queue filled as memory responses are driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        consume;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q [$];

    fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ack    (imem_ack),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_consume     (consume),
        .o_valid       (valid),
        .o_instr       (instr),
        .o_pc          (pc),
        .o_count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'd3 + 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            next_cycle();
            n++;
        end
        chk("req_timeout", 32'(n < 50), 32'd1);
    endtask

    // Issue one request with ack, answer after lat cycles, record the entry.
    task automatic fetch_one(input int lat);
        logic [31:0] a;
        wait_req();
        a = imem_addr;
        exp_q.push_back({a, mem_word(a)});
        imem_ack = 1'b1;
        next_cycle();
        imem_ack = 1'b0;
        repeat (lat - 1) next_cycle();
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(a);
        next_cycle();
        imem_rvalid = 1'b0;
    endtask

    // Compare head against the oldest expected entry, then consume it.
    task automatic pop_check(input string tag);
        logic [63:0] e;
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_qempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_pc"}, pc, e[63:32]);
            chk({tag, "_instr"}, instr, e[31:0]);
        end
        consume = 1'b1;
        next_cycle();
        consume = 1'b0;
    endtask

    initial begin
        logic [63:0] e;
        rst = 1'b0; imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; consume = 1'b0;

        // Reset state
        next_cycle();
        next_cycle();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);

        // Cold start
        rst = 1'b1;
        #1;
        chk("cold_req", 32'(imem_req), 32'd1);
        chk("cold_addr", imem_addr, 32'h0);
        fetch_one(1);
        chk("cold_valid", 32'(valid), 32'd1);
        chk("cold_pc", pc, 32'h0);
        chk("cold_instr", instr, 32'h0000_0013);
        chk("cold_next_req", 32'(imem_req), 32'd1);
        chk("cold_next_addr", imem_addr, 32'h4);

        // Fill to DEPTH with no consumption
        fetch_one(1);
        fetch_one(1);
        fetch_one(1);
        chk("fill_count", 32'(count), 32'd4);
        repeat (3) begin
            chk("fill_req_low", 32'(imem_req), 32'd0);
            next_cycle();
        end
        pop_check("fill_head");
        chk("fill_count3", 32'(count), 32'd3);
        chk("fill_req_again", 32'(imem_req), 32'd1);
        chk("fill_addr16", imem_addr, 32'h10);

        // Simultaneous write and consume with two entries buffered
        pop_check("sim_pre");
        chk("sim_count2", 32'(count), 32'd2);
        wait_req();
        chk("sim_addr", imem_addr, 32'h10);
        exp_q.push_back({imem_addr, mem_word(imem_addr)});
        imem_ack = 1'b1;
        next_cycle();
        imem_ack = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'h10);
        e = exp_q.pop_front();
        chk("sim_head_pc", pc, e[63:32]);
        consume = 1'b1;
        next_cycle();
        imem_rvalid = 1'b0;
        consume = 1'b0;
        chk("sim_count_hold", 32'(count), 32'd2);
        chk("sim_head_next", pc, exp_q[0][63:32]);

        // Redirect while waiting for a response with three entries buffered
        fetch_one(1);
        chk("rdw_count3", 32'(count), 32'd3);
        wait_req();
        imem_ack = 1'b1;
        next_cycle();
        imem_ack = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        next_cycle();
        redirect = 1'b0;
        exp_q.delete();
        chk("rdw_count0", 32'(count), 32'd0);
        chk("rdw_valid0", 32'(valid), 32'd0);
        chk("rdw_req_low", 32'(imem_req), 32'd0);
        next_cycle();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        next_cycle();
        imem_rvalid = 1'b0;
        chk("rdw_stale_valid", 32'(valid), 32'd0);
        chk("rdw_req", 32'(imem_req), 32'd1);
        chk("rdw_addr", imem_addr, 32'h100);
        fetch_one(2);
        chk("rdw_count1", 32'(count), 32'd1);
        pop_check("rdw_head");

        // Redirect coinciding with an accepted request
        wait_req();
        imem_ack = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0203;
        next_cycle();
        imem_ack = 1'b0;
        redirect = 1'b0;
        chk("rda_req_low", 32'(imem_req), 32'd0);
        chk("rda_count0", 32'(count), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        next_cycle();
        imem_rvalid = 1'b0;
        chk("rda_stale_valid", 32'(valid), 32'd0);
        chk("rda_req", 32'(imem_req), 32'd1);
        chk("rda_addr", imem_addr, 32'h200);
        fetch_one(1);
        pop_check("rda_head");

        // Reset with a request outstanding, then a stray response
        wait_req();
        imem_ack = 1'b1;
        next_cycle();
        imem_ack = 1'b0;
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        next_cycle();
        imem_rvalid = 1'b0;
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_addr", imem_addr, 32'h0);

        // Fetch address wrap
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        next_cycle();
        redirect = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        fetch_one(1);
        fetch_one(1);
        pop_check("wrap_first");
        pop_check("wrap_second");
        chk("wrap_empty", 32'(valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_prefetch_buffer.md
# fetch_prefetch_buffer

Instruction prefetch stage sitting directly upstream of the core's fetch stage. Issues sequential word fetches to instruction memory over a request/acknowledge plus response-valid handshake, buffers up to DEPTH instruction/PC pairs, and presents the oldest pair to the fetch stage. On a taken branch/jump redirect from the execute stage it flushes all buffered entries, discards any in-flight response, and restarts fetching at the redirect target.

## Interface
- DEPTH, 4, buffer entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  synchronous, active-low reset
- o_imem_req  output  1  fetch request valid
- o_imem_addr  output  32  fetch word address; bits [1:0] always 0
- i_imem_ack  input  1  request accepted this cycle (req & ack = transfer)
- i_imem_rvalid  input  1  response data valid
- i_imem_rdata  input  32  instruction word
- i_redirect  input  1  flush and restart (execute-stage pc_src taken)
- i_redirect_pc  input  32  restart address; bits [1:0] ignored
- i_consume  input  1  fetch stage takes head entry this cycle (= not stalled)
- o_valid  output  1  head entry present
- o_instr  output  32  head instruction
- o_pc  output  32  head instruction address
- o_count  output  $clog2(DEPTH)+1  occupied entries

## Operation
- State: fetch_pc (32b), circular buffer with rd/wr pointers, count, FSM {FETCH, WAIT, DISCARD}.
- FETCH: o_imem_req = (count < DEPTH); o_imem_addr = fetch_pc. On req & ack: fetch_pc += 4 (wraps modulo 2^32), go WAIT. Address held stable while req high and not acked.
- WAIT: o_imem_req = 0. On rvalid: write {rdata, pc-of-request} at wr pointer, count+1, go FETCH. Space is guaranteed because a request issues only when count < DEPTH.
- DISCARD: o_imem_req = 0. On rvalid: drop data, go FETCH.
- Redirect (highest priority, any state): buffer cleared (count = 0, pointers = 0); fetch_pc = {i_redirect_pc[31:2], 2'b00}; i_consume ignored that cycle. Next state: WAIT → DISCARD (unless rvalid same cycle: then response dropped, → FETCH); FETCH with req & ack same cycle → DISCARD (accepted stale request); otherwise → FETCH. DISCARD stays DISCARD until rvalid.
- o_valid = (count != 0); o_instr/o_pc driven from head entry registers; undefined-but-stable when o_valid = 0.
- i_consume with count = 0: ignored. Write and consume in same cycle: count unchanged, both pointers advance.
- Pointers wrap at DEPTH.

## Timing
- Reset (i_rst = 0 at edge): state FETCH, fetch_pc = RESET_PC, count = 0, pointers = 0. While i_rst low: o_imem_req = 0, o_valid = 0, o_count = 0, o_imem_addr = RESET_PC.
- First cycle after reset release: o_imem_req = 1, o_imem_addr = RESET_PC.
- i_imem_rvalid never arrives in the same cycle as the ack for its request; minimum ack→rvalid latency 1 cycle.
- Request acked in cycle N, rvalid in cycle N+k: entry visible (o_valid = 1) in N+k+1; next request asserted in N+k+1.
- At most one outstanding request; peak throughput one instruction per 2 cycles at 1-cycle memory latency.
- Redirect in cycle N: o_valid = 0 and o_count = 0 from N+1; first request to new target no earlier than N+1 (later if a stale response is pending).
- Reset mid-transaction: outstanding request forgotten; a later stray rvalid in FETCH is ignored.

## Test plan
- Reset/cold start: release reset, ack immediately, rvalid 1 cycle later with 32'h00000013 → req at addr 0, then o_valid = 1, o_pc = 0, o_instr = 32'h00000013; next req addr 4.
- Fill/backpressure: DEPTH = 4, i_consume = 0, memory 1-cycle → exactly 4 entries (pc 0,4,8,C), o_count = 4, o_imem_req stays 0; single consume → req reasserts at addr 16.
- Simultaneous write and consume with count = 2 → count stays 2, head advances to next PC, order preserved.
- Redirect in WAIT to 32'h00000100 with 3 entries buffered, stale rvalid 2 cycles later → o_count = 0 next cycle, stale data never appears, next req addr 32'h100, head o_pc = 32'h100.
- Redirect in same cycle as req & ack → FSM enters DISCARD, stale response dropped; redirect_pc 32'h00000203 fetches from 32'h200.
- fetch_pc wrap: redirect to 32'hFFFFFFFC, two fetches → o_pc values 32'hFFFFFFFC then 32'h00000000.
